// File: rtl/piso_shift_tx.sv
// +----------------------------------------------------------------------------+
// | piso_shift_tx : parallel-in serial-out transmitter, MSB first, with shift   |
// |                 strobe for a downstream left-shifting receive register.     |
// | Optional: PIS_TX_PARITY_EN appends one even-parity bit per frame.           |
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module piso_shift_tx #(
  parameter int REG_SIZE = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [REG_SIZE-1:0] x,
  input  logic                load,
  output logic                ready,
  output logic                sout,
  output logic                shl,
  output logic                busy,
  output logic                done
);

  localparam int C_CNT_W = (REG_SIZE > 2) ? $clog2(REG_SIZE) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(REG_SIZE - 1);
`ifndef PIS_TX_PARITY_EN
  localparam logic [C_CNT_W-1:0] C_CNT_PEN  = C_CNT_W'(REG_SIZE - 2);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef PIS_TX_PARITY_EN
    ,PAR  = 2'd2
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [REG_SIZE-1:0] sr_q, sr_d;
  logic [C_CNT_W-1:0]  cnt_q, cnt_d;
  logic                sout_q, sout_d;
  logic                shl_q, shl_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef PIS_TX_PARITY_EN
  logic                par_q, par_d;
`endif
  logic                w_accept;

  // A new word may be taken while the frame's final bit is on the line,
  // which is what makes back-to-back frames gapless.
  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      IDLE:    ready = 1'b1;
`ifdef PIS_TX_PARITY_EN
      SHIFT:   ready = 1'b0;
      PAR:     ready = 1'b1;
`else
      SHIFT:   ready = (cnt_q == C_CNT_LAST);
`endif
      default: ready = 1'b0;
    endcase
  end

  assign w_accept = load & ready;

  // The serial outputs are registered, so each edge loads the bit that will
  // be presented during the following cycle; sr holds the bits still to go.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    sout_d  = 1'b0;
    shl_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef PIS_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (w_accept) begin
      state_d = SHIFT;
      sr_d    = {x[REG_SIZE-2:0], 1'b0};
      cnt_d   = '0;
      sout_d  = x[REG_SIZE-1];
      shl_d   = 1'b1;
      busy_d  = 1'b1;
`ifdef PIS_TX_PARITY_EN
      par_d   = ^x;
`endif
    end else begin
      unique case (state_q)
        SHIFT: begin
          if (cnt_q != C_CNT_LAST) begin
            sr_d   = {sr_q[REG_SIZE-2:0], 1'b0};
            cnt_d  = cnt_q + C_CNT_W'(1);
            sout_d = sr_q[REG_SIZE-1];
            shl_d  = 1'b1;
            busy_d = 1'b1;
`ifndef PIS_TX_PARITY_EN
            done_d = (cnt_q == C_CNT_PEN);
`endif
          end else begin
`ifdef PIS_TX_PARITY_EN
            state_d = PAR;
            sout_d  = par_q;
            shl_d   = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b1;
`else
            state_d = IDLE;
            cnt_d   = '0;
`endif
          end
        end
`ifdef PIS_TX_PARITY_EN
        PAR: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b0;
      shl_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PIS_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      shl_q   <= shl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PIS_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign sout = sout_q;
  assign shl  = shl_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

`default_nettype wire
